// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers an NxN X/W tile and streams it diagonally skewed into a systolic array
// Optional second tile buffer: define SYSTOLIC_FEEDER_DBUF_EN.
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_x,
  input  logic [N*W-1:0] in_w,
  input  logic           stall,
  output logic           start,
  output logic [N*W-1:0] x_out,
  output logic [N*W-1:0] w_out,
  output logic           done
);

  typedef logic [W-1:0] word_t;
  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_FLUSH, S_DONE} state_t;

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(2 * N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  r_f;
  logic [TW-1:0]  r_t;
  logic [N*W-1:0] r_x_out;
  logic [N*W-1:0] r_w_out;
  logic [N*W-1:0] w_x_step;
  logic [N*W-1:0] w_w_step;
  logic [TW-1:0]  w_off;
  logic [KW-1:0]  w_wr_idx;
  logic [KW-1:0]  w_k_done;
  logic           w_accept;
  logic           w_wr_en;
  logic           w_swap;

  assign w_accept = in_valid && in_ready;
  assign w_wr_en  = w_accept && !rst;
  assign start    = (r_state == S_STREAM) || (r_state == S_FLUSH);
  assign done     = (r_state == S_DONE);
  assign x_out    = r_x_out;
  assign w_out    = r_w_out;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  word_t         r_xbuf [2][N][N];
  word_t         r_wbuf [2][N][N];
  logic          r_rd_bank;
  logic          r_sh_full;
  logic [KW-1:0] r_sk;
  logic [KW-1:0] w_sk_nxt;
  logic          w_sh_full_nxt;
  logic          w_sh_acc;
  logic          w_wr_bank;

  // Outside LOAD, accepted beats go to the shadow bank regardless of stall.
  assign in_ready      = (r_state == S_LOAD) || !r_sh_full;
  assign w_sh_acc      = w_accept && (r_state != S_LOAD);
  assign w_wr_bank     = (r_state == S_LOAD) ? r_rd_bank : !r_rd_bank;
  assign w_wr_idx      = (r_state == S_LOAD) ? r_k : r_sk;
  assign w_sk_nxt      = w_sh_acc ? ((r_sk == K_LAST) ? '0 : r_sk + KW'(1)) : r_sk;
  assign w_sh_full_nxt = r_sh_full || (w_sh_acc && (r_sk == K_LAST));
  assign w_swap        = w_sh_full_nxt;
  // A partially filled shadow becomes the load bank, so LOAD resumes at its beat count.
  assign w_k_done      = w_sk_nxt;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < N; i++) begin
        r_xbuf[w_wr_bank][i][w_wr_idx] <= in_x[i*W +: W];
        r_wbuf[w_wr_bank][w_wr_idx][i] <= in_w[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_sk      <= '0;
      r_sh_full <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_rd_bank <= !r_rd_bank;
      r_sk      <= '0;
      r_sh_full <= 1'b0;
    end else begin
      r_sk      <= w_sk_nxt;
      r_sh_full <= w_sh_full_nxt;
    end
  end
`else
  word_t r_xbuf [N][N];
  word_t r_wbuf [N][N];

  assign in_ready = (r_state == S_LOAD);
  assign w_wr_idx = r_k;
  assign w_swap   = 1'b0;
  assign w_k_done = '0;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < N; i++) begin
        r_xbuf[i][w_wr_idx] <= in_x[i*W +: W];
        r_wbuf[w_wr_idx][i] <= in_w[i*W +: W];
      end
    end
  end
`endif

  // Lane i carries element t-i of its row/column; outside 0..N-1 the lane is zero.
  always_comb begin
    w_x_step = '0;
    w_w_step = '0;
    w_off    = '0;
    for (int i = 0; i < N; i++) begin
      w_off = r_t - TW'(i);
      if ((r_t >= TW'(i)) && (w_off < TW'(N))) begin
`ifdef SYSTOLIC_FEEDER_DBUF_EN
        w_x_step[i*W +: W] = r_xbuf[r_rd_bank][i][w_off[KW-1:0]];
        w_w_step[i*W +: W] = r_wbuf[r_rd_bank][w_off[KW-1:0]][i];
`else
        w_x_step[i*W +: W] = r_xbuf[i][w_off[KW-1:0]];
        w_w_step[i*W +: W] = r_wbuf[w_off[KW-1:0]][i];
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:   if (w_accept && (r_k == K_LAST)) w_state_nxt = S_STREAM;
      S_STREAM: if (!stall && (r_t == T_LAST)) w_state_nxt = S_FLUSH;
      S_FLUSH:  if (!stall && (r_f == K_LAST)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = w_swap ? S_STREAM : S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_k     <= '0;
      r_t     <= '0;
      r_f     <= '0;
      r_x_out <= '0;
      r_w_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_LOAD: begin
          if (w_accept) r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
        end
        S_STREAM: begin
          if (!stall) begin
            r_x_out <= w_x_step;
            r_w_out <= w_w_step;
            r_t     <= (r_t == T_LAST) ? '0 : r_t + TW'(1);
          end
        end
        S_FLUSH: begin
          if (!stall) begin
            r_x_out <= '0;
            r_w_out <= '0;
            r_f     <= (r_f == K_LAST) ? '0 : r_f + KW'(1);
          end
        end
        S_DONE: begin
          r_k <= w_k_done;
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed-vector bench for systolic_feeder (N=4, W=32)
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int W = 32;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_x;
  logic [N*W-1:0] in_w;
  logic           stall;
  logic           start;
  logic [N*W-1:0] x_out;
  logic [N*W-1:0] w_out;
  logic           done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int             step;
    logic [N*W-1:0] x;
    logic [N*W-1:0] w;
  } vec_t;
  vec_t vecs [7];

  systolic_feeder #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .stall    (stall),
    .start    (start),
    .x_out    (x_out),
    .w_out    (w_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*W-1:0] p4(input logic [31:0] a3, input logic [31:0] a2,
                                        input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [N*W-1:0] mk_x(input int k);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = 32'(16 * i + k);
    return v;
  endfunction

  function automatic logic [N*W-1:0] mk_w(input int k);
    logic [N*W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*W +: W] = 32'(256 + 16 * k + j);
    return v;
  endfunction

  task automatic chk_v(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Offers the tile; gap cycles carry junk data that must never be captured.
  task automatic load_tile(input bit toggle);
    int beats;
    int it;
    bit acc;
    beats = 0;
    it    = 0;
    cyc   = 1;
    while (beats < N && it < 4 * N) begin
      in_valid = toggle ? ((it % 2) == 0) : 1'b1;
      in_x     = in_valid ? mk_x(beats) : {N{32'hDEAD_BEEF}};
      in_w     = in_valid ? mk_w(beats) : {N{32'hBAD0_F00D}};
      chk_b("load_ready", in_ready, 1'b1);
      acc = in_valid && in_ready;
      tick();
      if (acc) beats++;
      it++;
    end
    in_valid = 1'b0;
    chk_i("load_beats", beats, N);
  endtask

  task automatic wait_done(input int exp_cyc);
    int n;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk_b("done_seen", done, 1'b1);
    chk_i("done_cycle", cyc, exp_cyc);
    chk_b("done_start_low", start, 1'b0);
  endtask

  task automatic stream_tile(input int stall_len, input int exp_done);
    chk_b("stream_start", start, 1'b1);
    chk_b("stream_ready", in_ready, DBUF);
    for (int s = 0; s < 7; s++) begin
      tick();
      chk_v($sformatf("x_step%0d", vecs[s].step), x_out, vecs[s].x);
      chk_v($sformatf("w_step%0d", vecs[s].step), w_out, vecs[s].w);
      if (s == 2 && stall_len > 0) begin
        stall = 1'b1;
        for (int c = 0; c < stall_len; c++) begin
          tick();
          chk_v("x_stall_hold", x_out, vecs[2].x);
          chk_v("w_stall_hold", w_out, vecs[2].w);
          chk_b("start_stall", start, 1'b1);
        end
        stall = 1'b0;
      end
    end
    tick();
    chk_v("x_flush", x_out, '0);
    chk_v("w_flush", w_out, '0);
    chk_b("start_flush", start, 1'b1);
    wait_done(exp_done);
    tick();
    chk_b("done_one_cycle", done, 1'b0);
    chk_b("idle_ready", in_ready, 1'b1);
    chk_b("idle_start", start, 1'b0);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{0, p4(0, 0, 0, 0),             p4(0, 0, 0, 'h100)};
    vecs[1] = '{1, p4(0, 0, 'h10, 'h01),       p4(0, 0, 'h101, 'h110)};
    vecs[2] = '{2, p4(0, 'h20, 'h11, 'h02),    p4(0, 'h102, 'h111, 'h120)};
    vecs[3] = '{3, p4('h30, 'h21, 'h12, 'h03), p4('h103, 'h112, 'h121, 'h130)};
    vecs[4] = '{4, p4('h31, 'h22, 'h13, 0),    p4('h113, 'h122, 'h131, 0)};
    vecs[5] = '{5, p4('h32, 'h23, 0, 0),       p4('h123, 'h132, 0, 0)};
    vecs[6] = '{6, p4('h33, 0, 0, 0),          p4('h133, 0, 0, 0)};

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_x = '0; in_w = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_b("rst_ready", in_ready, 1'b1);
    chk_b("rst_start", start, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_v("rst_x", x_out, '0);
    chk_v("rst_w", w_out, '0);

    load_tile(1'b0);
    stream_tile(0, 16);

    load_tile(1'b0);
    stream_tile(3, 19);

    load_tile(1'b1);
    stream_tile(0, 19);

    // Reset in mid-stream, with in_valid and stall also asserted.
    load_tile(1'b0);
    for (int s = 0; s < 5; s++) tick();
    chk_v("pre_rst_x_step4", x_out, vecs[4].x);
    rst = 1'b1; in_valid = 1'b1; stall = 1'b1;
    in_x = {N{32'hDEAD_BEEF}}; in_w = {N{32'hBAD0_F00D}};
    tick();
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0;
    chk_v("midrst_x", x_out, '0);
    chk_v("midrst_w", w_out, '0);
    chk_b("midrst_start", start, 1'b0);
    chk_b("midrst_ready", in_ready, 1'b1);
    chk_b("midrst_done", done, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk_b("no_done_after_rst", seen, 1'b0);
    load_tile(1'b0);
    stream_tile(0, 16);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    load_tile(1'b0);
    for (int b = 0; b < N; b++) begin
      chk_b("shadow_ready", in_ready, 1'b1);
      in_valid = 1'b1; in_x = mk_x(b); in_w = mk_w(b);
      tick();
    end
    in_valid = 1'b0;
    chk_b("shadow_full_ready", in_ready, 1'b0);
    chk_v("dbuf_x_step3", x_out, vecs[3].x);
    wait_done(16);
    tick();
    chk_b("swap_start", start, 1'b1);
    chk_b("swap_done_low", done, 1'b0);
    tick();
    chk_v("tile2_x_step0", x_out, vecs[0].x);
    chk_v("tile2_w_step0", w_out, vecs[0].w);
    tick();
    chk_v("tile2_x_step1", x_out, vecs[1].x);
    wait_done(28);
    tick();
    chk_b("tile2_idle_start", start, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
